r200_fetchq: RTL and testbench

R200_FETCHQ -- requirements
Module: r200_fetchq

---
 rtl/r200_fetchq.sv | 130 +++++++++++++
 tb/tb_r200_fetchq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/r200_fetchq.sv
// Instruction fetch queue: one outstanding imem read at a time, results buffered
// in a DEPTH-entry FIFO of {instruction, pc}; redirect flushes and refetches.
module r200_fetchq #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_instrn,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pcp4,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, WAIT_STALE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic            push, pop, has_room;
    logic [XLEN-1:0] redir_pc;
    logic            unused_lsbs;

    assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_lsbs = ^redirect_pc[1:0];
    assign has_room    = count_q < CW'(DEPTH);
    assign deq_valid   = count_q != '0;
    assign pop         = deq_valid && deq_ready && !redirect;
    assign count       = count_q;
    assign deq_instrn  = instr_q[rd_ptr_q];
    assign deq_pc      = pc_q[rd_ptr_q];
    assign deq_pcp4    = pc_q[rd_ptr_q] + XLEN'(4);

    // The issued address is latched separately so a redirect while waiting can
    // move fetch_pc without disturbing the request still on the bus.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        imem_req   = 1'b0;
        imem_addr  = fetch_pc_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && has_room) begin
                    imem_req   = 1'b1;
                    req_addr_d = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                if (imem_ack) begin
                    state_d = IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = req_addr_q + XLEN'(4);
                    end
                end else if (redirect) begin
                    state_d = WAIT_STALE;
                end
            end
            WAIT_STALE: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) fetch_pc_d = redir_pc;
        if (rst) imem_req = 1'b0;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]    <= req_addr_q;
        end
    end
endmodule

// File: tb/tb_r200_fetchq.sv
// Bench for r200_fetchq: queue-level reference model checked every cycle,
// plus hand-computed checkpoints along a directed scenario.
module tb_r200_fetchq;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, redirect, deq_valid, deq_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, deq_instrn, deq_pc, deq_pcp4;
    logic [2:0]  count;
    logic        auto_ack, ack_force, req_prev;
    int          n_tot = 0, n_pass = 0;

    r200_fetchq #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_instrn(deq_instrn), .deq_pc(deq_pc), .deq_pcp4(deq_pcp4), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory: data is a function of address; auto mode acks one cycle after a new request.
    assign imem_rdata = instr_of(imem_addr);
    assign imem_ack   = ack_force | (auto_ack & imem_req & req_prev);
    always @(posedge clk) req_prev <= rst ? 1'b0 : (imem_req & ~imem_ack);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a queue of fetched entries plus an outstanding-request record.
    typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
    ent_t        q[$];
    ent_t        pe;
    bit          m_init = 0, m_pend, m_stale, e_req, do_pop, do_push;
    logic [31:0] m_fpc, m_raddr;

    always @(negedge clk) begin
        e_req = !rst && (m_pend || (!redirect && q.size() < DEPTH));
        if (m_init) begin
            chk("imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) chk("imem_addr", imem_addr, m_pend ? m_raddr : m_fpc);
            chk("count", 32'(count), q.size());
            chk("deq_valid", 32'(deq_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("deq_pc", deq_pc, q[0].pc);
                chk("deq_instrn", deq_instrn, q[0].ins);
                chk("deq_pcp4", deq_pcp4, q[0].pc + 32'd4);
            end
        end
        if (rst) begin
            m_init = 1; m_pend = 0; m_stale = 0; m_fpc = 32'h0; q.delete();
        end else begin
            do_pop  = q.size() != 0 && deq_ready;
            do_push = 0;
            if (m_pend) begin
                if (imem_ack) begin
                    if (!m_stale && !redirect) begin
                        pe = '{instr_of(m_raddr), m_raddr};
                        do_push = 1;
                        m_fpc = m_raddr + 32'd4;
                    end
                    m_pend = 0; m_stale = 0;
                end else if (redirect) m_stale = 1;
            end else if (e_req) begin
                m_pend = 1; m_raddr = m_fpc;
            end
            if (redirect) begin
                q.delete();
                m_fpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(pe);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [31:0] rec_pc [3];
    logic [31:0] rec_p4 [3];
    int          nrec;

    initial begin
        rst = 1; redirect = 0; redirect_pc = 0; deq_ready = 0; auto_ack = 0; ack_force = 0;
        repeat (3) step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        rst = 0; auto_ack = 1;
        #1 chk("first_addr", imem_addr, 32'h0);
        chk("first_req", 32'(imem_req), 32'd1);

        // Fill with no consumer: PCs 0,4,8,12 and requests stop
        repeat (12) step();
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_req", 32'(imem_req), 32'd0);
        chk("fill_pc", deq_pc, 32'h0);
        chk("fill_ins", deq_instrn, 32'hFFFF_0000);

        // Three pops, the last one coincident with the push of 0x10
        deq_ready = 1;
        repeat (3) step();
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_pc", deq_pc, 32'hC);
        chk("pp_req", 32'(imem_req), 32'd1);
        chk("pp_addr", imem_addr, 32'h14);
        auto_ack = 0; deq_ready = 0;

        // Redirect while waiting: request stays, data discarded
        step();
        redirect = 1; redirect_pc = 32'h103;
        step();
        redirect = 0;
        chk("stale_count", 32'(count), 32'd0);
        chk("stale_req", 32'(imem_req), 32'd1);
        chk("stale_addr", imem_addr, 32'h14);
        ack_force = 1;
        step();
        ack_force = 0; auto_ack = 1;
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_count", 32'(count), 32'd0);
        repeat (2) step();
        chk("redir_pc", deq_pc, 32'h100);
        chk("redir_pcp4", deq_pcp4, 32'h104);

        // Redirect coincident with ack, then redirect blocking issue
        step();
        redirect = 1; redirect_pc = 32'h200;
        step();
        chk("coinc_count", 32'(count), 32'd0);
        chk("coinc_addr", imem_addr, 32'h200);
        redirect_pc = 32'h300;
        #1 chk("redir_blocks_req", 32'(imem_req), 32'd0);
        step();
        redirect = 0;
        #1 chk("post_redir_addr", imem_addr, 32'h300);
        ack_force = 1;
        step();
        ack_force = 0;
        step();

        // Address wrap past 2^32-4 while streaming
        redirect = 1; redirect_pc = 32'hFFFF_FFFB; deq_ready = 1;
        step();
        redirect = 0; nrec = 0;
        for (int i = 0; i < 30; i++) begin
            if (deq_valid && nrec < 3) begin
                rec_pc[nrec] = deq_pc; rec_p4[nrec] = deq_pcp4; nrec++;
            end
            step();
        end
        chk("wrap_seen", nrec, 3);
        if (nrec == 3) begin
            chk("wrap_pc0", rec_pc[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", rec_pc[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", rec_pc[2], 32'h0);
            chk("wrap_pcp4", rec_p4[1], 32'h0);
        end

        // Reset with three entries queued and a request outstanding
        redirect = 1; redirect_pc = 32'h400; deq_ready = 0;
        step();
        redirect = 0;
        for (int i = 0; i < 20 && count != 3; i++) step();
        chk("mid_fill", 32'(count), 32'd3);
        auto_ack = 0;
        step();
        chk("mid_wait_req", 32'(imem_req), 32'd1);
        rst = 1;
        step();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(deq_valid), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        rst = 0;
        #1 chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        auto_ack = 1; deq_ready = 1;
        repeat (12) step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
